// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle main control.
// Contents: FSM state enum, decoded opcode class enum, 11-bit opcode
// constants, and the ALUSrcB / ALUOperation / PCSource encodings.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    LD_MEM   = 4'd3,
    LD_WB    = 4'd4,
    ST_MEM   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    CBZ_EXEC = 4'd8,
    B_EXEC   = 4'd9,
    TRAP     = 4'd10
  } ctrl_state_e;

  typedef enum logic [2:0] {
    CLS_LD      = 3'd0,
    CLS_ST      = 3'd1,
    CLS_RTYPE   = 3'd2,
    CLS_CBZ     = 3'd3,
    CLS_B       = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_e;

  // Exact opcodes; the wildcard groups live in the decoder's casez.
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

endpackage

// File: rtl/legv8_ctrl_opcode_decode.sv
// Combinational opcode classifier.
//   Operation [10:0] in  : IR[31:21]
//   op_class  [2:0]  out : LD / ST / RTYPE / CBZ / B / ILLEGAL
module legv8_opcode_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] Operation,
  output op_class_e   op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    casez (Operation)
      OP_LDUR:        op_class = CLS_LD;
      OP_STUR:        op_class = CLS_ST;
      // ADD/SUB/AND/ORR share bit 10 set, 0101 in [7:4], 000 in [2:0]
      11'b1??0101?000: op_class = CLS_RTYPE;
      11'b10110100???: op_class = CLS_CBZ;
      11'b000101?????: op_class = CLS_B;
      default:        op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle main control FSM for the LEGv8 datapath (LDUR/STUR/ADD/SUB/
// AND/ORR/CBZ/B), with a bounded-wait handshake to a unified memory.
//   clk, rst_n (sync, active low)
//   Operation[10:0] IR[31:21], only looked at in DECODE
//   zero            ALU zero flag, used in CBZ_EXEC
//   mem_ready       memory completes the current access this cycle
//   mem_req, MemRead, MemWrite, IorD       memory side
//   IRWrite, PCWrite, PCSource[1:0]        fetch / PC update
//   Reg2Loc, RegWrite, MemtoReg            register file
//   ALUSrcA, ALUSrcB[1:0], ALUOperation[1:0]  ALU muxing / alu_control
//   trap            sticky halt on illegal opcode or memory timeout
// MEM_TIMEOUT: wait cycles allowed in a memory state before TRAP (0 = never).
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] Operation,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSource,
  output logic        Reg2Loc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOperation,
  output logic        trap
);

  localparam bit TO_EN = (MEM_TIMEOUT > 0);
  // Counter only has to hold 0..MEM_TIMEOUT-1: the last wait cycle goes to TRAP.
  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(MEM_TIMEOUT - 1) : '0;

  ctrl_state_e state_q, state_d;
  op_class_e   class_q, class_d;
  op_class_e   dec_class;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        mem_state;
  logic        timeout_hit;

  legv8_opcode_decode u_dec (
    .Operation (Operation),
    .op_class  (dec_class)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      class_q <= CLS_ILLEGAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
    end
  end

  // mem_ready in the final allowed wait cycle still completes the access,
  // so the timeout only fires when ready is low on that cycle.
  always_comb begin
    mem_state   = (state_q == FETCH) || (state_q == LD_MEM) || (state_q == ST_MEM);
    timeout_hit = TO_EN && mem_state && !mem_ready && (cnt_q == CNT_LAST);
    cnt_d       = '0;
    if (TO_EN && mem_state && !mem_ready && !timeout_hit)
      cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    mem_req      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IorD         = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCSource     = PCSRC_ALU;
    Reg2Loc      = 1'b0;
    RegWrite     = 1'b0;
    MemtoReg     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REG;
    ALUOperation = ALUOP_ADD;
    trap         = 1'b0;

    unique case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // IR and PC+4 may only be latched on the cycle the fetch completes.
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end else if (timeout_hit) begin
          state_d = TRAP;
        end
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        Reg2Loc = (dec_class == CLS_ST) || (dec_class == CLS_CBZ);
        class_d = dec_class;
        unique case (dec_class)
          CLS_LD, CLS_ST: state_d = MEM_ADDR;
          CLS_RTYPE:      state_d = R_EXEC;
          CLS_CBZ:        state_d = CBZ_EXEC;
          CLS_B:          state_d = B_EXEC;
          default:        state_d = TRAP;
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (class_q == CLS_LD) ? LD_MEM : ST_MEM;
      end
      LD_MEM: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)        state_d = LD_WB;
        else if (timeout_hit) state_d = TRAP;
      end
      LD_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = FETCH;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
        if (mem_ready)        state_d = FETCH;
        else if (timeout_hit) state_d = TRAP;
      end
      R_EXEC: begin
        ALUSrcA      = 1'b1;
        ALUOperation = ALUOP_RTYPE;
        state_d      = R_WB;
      end
      R_WB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      CBZ_EXEC: begin
        ALUSrcA      = 1'b1;
        ALUOperation = ALUOP_PASSB;
        Reg2Loc      = 1'b1;
        PCSource     = PCSRC_ALUOUT;
        PCWrite      = zero;
        state_d      = FETCH;
      end
      B_EXEC: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_ALUOUT;
        state_d  = FETCH;
      end
      TRAP: begin
        trap = 1'b1;
      end
      // Unused encodings halt rather than wander.
      default: state_d = TRAP;
    endcase
  end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
module tb_legv8_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] Operation;
  logic        zero, mem_ready;
  logic        mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite;
  logic [1:0]  PCSource;
  logic        Reg2Loc, RegWrite, MemtoReg, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOperation;
  logic        trap;
  logic [16:0] obs;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  legv8_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .Operation(Operation), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSource(PCSource), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOperation(ALUOperation), .trap(trap)
  );

  // {mem_req,MemRead,MemWrite,IorD,IRWrite,PCWrite,PCSource,Reg2Loc,
  //  RegWrite,MemtoReg,ALUSrcA,ALUSrcB,ALUOperation,trap}
  assign obs = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource,
                Reg2Loc, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOperation, trap};

  localparam logic [16:0] E_FETCH_WAIT = 17'b1_1_0_0_0_0_00_0_0_0_0_01_00_0;
  localparam logic [16:0] E_FETCH_RDY  = 17'b1_1_0_0_1_1_00_0_0_0_0_01_00_0;
  localparam logic [16:0] E_DECODE     = 17'b0_0_0_0_0_0_00_0_0_0_0_11_00_0;
  localparam logic [16:0] E_DECODE_R2L = 17'b0_0_0_0_0_0_00_1_0_0_0_11_00_0;
  localparam logic [16:0] E_MEM_ADDR   = 17'b0_0_0_0_0_0_00_0_0_0_1_10_00_0;
  localparam logic [16:0] E_LD_MEM     = 17'b1_1_0_1_0_0_00_0_0_0_0_00_00_0;
  localparam logic [16:0] E_LD_WB      = 17'b0_0_0_0_0_0_00_0_1_1_0_00_00_0;
  localparam logic [16:0] E_ST_MEM     = 17'b1_0_1_1_0_0_00_1_0_0_0_00_00_0;
  localparam logic [16:0] E_R_EXEC     = 17'b0_0_0_0_0_0_00_0_0_0_1_00_10_0;
  localparam logic [16:0] E_R_WB       = 17'b0_0_0_0_0_0_00_0_1_0_0_00_00_0;
  localparam logic [16:0] E_CBZ_Z1     = 17'b0_0_0_0_0_1_01_1_0_0_1_00_01_0;
  localparam logic [16:0] E_CBZ_Z0     = 17'b0_0_0_0_0_0_01_1_0_0_1_00_01_0;
  localparam logic [16:0] E_B_EXEC     = 17'b0_0_0_0_0_1_01_0_0_0_0_00_00_0;
  localparam logic [16:0] E_TRAP       = 17'b0_0_0_0_0_0_00_0_0_0_0_00_00_1;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Inputs are set before the call; #1 lets the combinational outputs settle.
  task automatic chk(input string tag, input logic [16:0] exp);
    #1;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; Operation = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (3) cyc();
    chk("reset_fetch", E_FETCH_WAIT);
    rst_n = 1'b1;

    // ADD, memory always ready: 4 cycles, then FETCH
    mem_ready = 1'b1; Operation = OP_ADD;
    chk("add_c1_fetch", E_FETCH_RDY);    cyc();
    chk("add_c2_decode", E_DECODE);      cyc();
    Operation = OP_BAD;                  // ignored after DECODE
    chk("add_c3_rexec", E_R_EXEC);       cyc();
    chk("add_c4_rwb", E_R_WB);           cyc();

    // LDUR, ready withheld for 3 LD_MEM cycles (last allowed wait wins)
    Operation = OP_LDUR;
    chk("ld_c1_fetch", E_FETCH_RDY);     cyc();
    chk("ld_c2_decode", E_DECODE);       cyc();
    mem_ready = 1'b0;
    chk("ld_c3_memaddr", E_MEM_ADDR);    cyc();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ld_wait%0d", i), E_LD_MEM); cyc();
    end
    mem_ready = 1'b1;
    chk("ld_c7_ready", E_LD_MEM);        cyc();
    chk("ld_c8_wb", E_LD_WB);            cyc();

    // CBZ: PCWrite follows zero in the same cycle
    Operation = OP_CBZ;
    chk("cbz_fetch", E_FETCH_RDY);       cyc();
    chk("cbz_decode_r2l", E_DECODE_R2L); cyc();
    zero = 1'b1;
    chk("cbz_exec_z1", E_CBZ_Z1);
    zero = 1'b0;
    chk("cbz_exec_z0", E_CBZ_Z0);        cyc();

    // B
    Operation = OP_B;
    chk("b_fetch", E_FETCH_RDY);         cyc();
    chk("b_decode", E_DECODE);           cyc();
    chk("b_exec", E_B_EXEC);             cyc();

    // ORR goes through the R-type path too
    Operation = OP_ORR;
    chk("orr_fetch", E_FETCH_RDY);       cyc();
    chk("orr_decode", E_DECODE);         cyc();
    chk("orr_rexec", E_R_EXEC);          cyc();
    chk("orr_rwb", E_R_WB);              cyc();

    // STUR, ready on the 4th (last allowed) wait cycle completes
    Operation = OP_STUR;
    chk("st_fetch", E_FETCH_RDY);        cyc();
    chk("st_decode_r2l", E_DECODE_R2L);  cyc();
    mem_ready = 1'b0;
    chk("st_memaddr", E_MEM_ADDR);       cyc();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st_wait%0d", i), E_ST_MEM); cyc();
    end
    mem_ready = 1'b1;
    chk("st_ready_c4", E_ST_MEM);        cyc();
    chk("st_back_fetch", E_FETCH_RDY);   cyc();

    // STUR timeout: 4 wait cycles then TRAP, no MemWrite after
    chk("sto_decode", E_DECODE_R2L);     cyc();
    mem_ready = 1'b0;
    chk("sto_memaddr", E_MEM_ADDR);      cyc();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sto_wait%0d", i), E_ST_MEM); cyc();
    end
    for (int i = 0; i < 5; i++) begin
      mem_ready = i[0];
      chk($sformatf("sto_trap%0d", i), E_TRAP); cyc();
    end
    rst_n = 1'b0; mem_ready = 1'b0;      cyc();
    rst_n = 1'b1;
    chk("sto_reset_fetch", E_FETCH_WAIT);

    // Reset in the middle of a store drops the write
    mem_ready = 1'b1;
    chk("rst_st_fetch", E_FETCH_RDY);    cyc();
    chk("rst_st_decode", E_DECODE_R2L);  cyc();
    mem_ready = 1'b0;
    chk("rst_st_memaddr", E_MEM_ADDR);   cyc();
    chk("rst_st_mem", E_ST_MEM);
    rst_n = 1'b0;                        cyc();
    chk("rst_st_dropped", E_FETCH_WAIT);
    rst_n = 1'b1;

    // Illegal opcode: TRAP after DECODE, absorbing for 20 cycles
    mem_ready = 1'b1; Operation = OP_BAD;
    chk("ill_fetch", E_FETCH_RDY);       cyc();
    chk("ill_decode", E_DECODE);         cyc();
    for (int i = 0; i < 20; i++) begin
      Operation = (i[0]) ? OP_ADD : OP_BAD;
      zero = i[1];
      chk($sformatf("ill_trap%0d", i), E_TRAP); cyc();
    end
    rst_n = 1'b0;                        cyc();
    rst_n = 1'b1;
    chk("ill_reset_fetch", E_FETCH_RDY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
